// File: rtl/id_stage_hz_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU control codes,
// immediate types, the ID/EX control bundle with its bubble value, and
// immediate/ALU helper functions.
package id_stage_hz_pkg;

    localparam int unsigned ILEN = 32;

    // RV32 base opcodes accepted by the decoder
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU control encodings; the M-extension group is {2'b10, funct3}
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASS_B = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic       write_enable;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       imm_select;
        logic       illegal;
        logic [4:0] alu_control;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    // 32-bit sign-extended immediate; R-type yields zero
    function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_type_e t);
        logic [31:0] imm;
        imm = '0;
        case (t)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // Base integer ALU op from funct3; alt selects SUB/SRA
    function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_hz_reg_file.sv
// reg_file_bypass: REG_COUNT x XLEN register file, two async read ports,
// one write port committed on the clock edge, write-through to same-cycle
// reads. Register 0 is hard zero. Synchronous active-high reset clears all.
// Ports: clk, rst, write_enable/write_addr/write_data,
//        read_addr1/read_data1, read_addr2/read_data2.
module reg_file_bypass #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32,
    localparam int unsigned AW       = $clog2(REG_COUNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write_enable,
    input  logic [AW-1:0]   write_addr,
    input  logic [XLEN-1:0] write_data,
    input  logic [AW-1:0]   read_addr1,
    output logic [XLEN-1:0] read_data1,
    input  logic [AW-1:0]   read_addr2,
    output logic [XLEN-1:0] read_data2
);

    logic [XLEN-1:0] regs [REG_COUNT];

    // Storage; x0 is never written so it stays zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && (write_addr != '0)) begin
            regs[write_addr] <= write_data;
        end
    end

    // Reads with write-through bypass
    always_comb begin
        read_data1 = regs[read_addr1];
        read_data2 = regs[read_addr2];
        if (write_enable && (write_addr != '0) && (write_addr == read_addr1)) begin
            read_data1 = write_data;
        end
        if (write_enable && (write_addr != '0) && (write_addr == read_addr2)) begin
            read_data2 = write_data;
        end
        if (read_addr1 == '0) begin
            read_data1 = '0;
        end
        if (read_addr2 == '0) begin
            read_data2 = '0;
        end
    end

endmodule

// File: rtl/id_stage_hz.sv
// id_stage_hz: RV32I/M decode stage with register file, immediate generation
// and load-use hazard detection, feeding one ID/EX output register.
// Inputs : CLK, RST (sync, active-high), IF_VALID/IF_PC/IF_INSTRUCTION,
//          WB_WRITE_ENABLE/WB_RD/WB_WRITE_DATA, EX_FLUSH.
// Outputs: ID_STALL (combinational), ID_* registered ID/EX payload.
module id_stage_hz
    import id_stage_hz_pkg::*;
#(
    parameter int unsigned   XLEN      = 32,
    parameter int unsigned   REG_COUNT = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int unsigned  AW        = $clog2(REG_COUNT)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IF_VALID,
    input  logic [XLEN-1:0] IF_PC,
    input  logic [31:0]     IF_INSTRUCTION,
    input  logic            WB_WRITE_ENABLE,
    input  logic [AW-1:0]   WB_RD,
    input  logic [XLEN-1:0] WB_WRITE_DATA,
    input  logic            EX_FLUSH,
    output logic            ID_STALL,
    output logic            ID_VALID,
    output logic [XLEN-1:0] ID_PC,
    output logic [XLEN-1:0] ID_PC_PLUS4,
    output logic [XLEN-1:0] ID_READ_DATA1,
    output logic [XLEN-1:0] ID_READ_DATA2,
    output logic [XLEN-1:0] ID_IMMEDIATE,
    output logic [AW-1:0]   ID_RS1,
    output logic [AW-1:0]   ID_RS2,
    output logic [AW-1:0]   ID_RD,
    output logic [2:0]      ID_FUNC3,
    output logic [4:0]      ID_ALU_CONTROL,
    output logic            ID_WRITE_ENABLE,
    output logic            ID_MEM_READ,
    output logic            ID_MEM_WRITE,
    output logic            ID_BRANCH,
    output logic            ID_JUMP,
    output logic            ID_IMM_SELECT,
    output logic            ID_ILLEGAL
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [AW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rdata1, rdata2;

    ctrl_t     ctrl;
    imm_type_e imm_type;
    logic      illegal, uses_rs1, uses_rs2, has_rd, has_func3;
    logic      hazard, load_live;

    logic            valid_d;
    logic [XLEN-1:0] pc_d, pc4_d, rd1_d, rd2_d, imm_d;
    logic [AW-1:0]   rs1_d, rs2_d, rd_d;
    logic [2:0]      f3_d;
    ctrl_t           ctrl_d;

    assign opcode = IF_INSTRUCTION[6:0];
    assign f3     = IF_INSTRUCTION[14:12];
    assign f7     = IF_INSTRUCTION[31:25];
    assign rs1    = AW'(IF_INSTRUCTION[19:15]);
    assign rs2    = AW'(IF_INSTRUCTION[24:20]);
    assign rd     = AW'(IF_INSTRUCTION[11:7]);

    reg_file_bypass #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT)
    ) u_reg_file (
        .clk          (CLK),
        .rst          (RST),
        .write_enable (WB_WRITE_ENABLE),
        .write_addr   (WB_RD),
        .write_data   (WB_WRITE_DATA),
        .read_addr1   (rs1),
        .read_data1   (rdata1),
        .read_addr2   (rs2),
        .read_data2   (rdata2)
    );

    // Instruction decode: controls, immediate type and operand usage
    always_comb begin
        ctrl      = BUBBLE_CTRL;
        imm_type  = IMM_R;
        illegal   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        has_rd    = 1'b0;
        has_func3 = 1'b1;
        case (opcode)
            OPC_LUI: begin
                ctrl.write_enable = 1'b1; ctrl.imm_select = 1'b1;
                ctrl.alu_control  = ALU_PASS_B;
                imm_type = IMM_U; has_rd = 1'b1; has_func3 = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl.write_enable = 1'b1; ctrl.imm_select = 1'b1;
                imm_type = IMM_U; has_rd = 1'b1; has_func3 = 1'b0;
            end
            OPC_JAL: begin
                ctrl.write_enable = 1'b1; ctrl.jump = 1'b1; ctrl.imm_select = 1'b1;
                imm_type = IMM_J; has_rd = 1'b1; has_func3 = 1'b0;
            end
            OPC_JALR: begin
                ctrl.write_enable = 1'b1; ctrl.jump = 1'b1; ctrl.imm_select = 1'b1;
                imm_type = IMM_I; has_rd = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1; ctrl.alu_control = ALU_SUB;
                imm_type = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.write_enable = 1'b1; ctrl.mem_read = 1'b1; ctrl.imm_select = 1'b1;
                imm_type = IMM_I; has_rd = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1; ctrl.imm_select = 1'b1;
                imm_type = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.write_enable = 1'b1; ctrl.imm_select = 1'b1;
                ctrl.alu_control  = alu_base(f3, (f3 == 3'b101) && f7[5]);
                imm_type = IMM_I; has_rd = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_OP: begin
                ctrl.write_enable = 1'b1;
                has_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                if (f7 == F7_MULDIV) begin
                    ctrl.alu_control = {2'b10, f3};
                end else if (f7 == F7_BASE) begin
                    ctrl.alu_control = alu_base(f3, 1'b0);
                end else if ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
                    ctrl.alu_control = alu_base(f3, 1'b1);
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        // Illegal instructions travel as valid but with every side effect off
        if (illegal) begin
            ctrl         = BUBBLE_CTRL;
            ctrl.illegal = 1'b1;
            imm_type     = IMM_R;
            uses_rs1     = 1'b0;
            uses_rs2     = 1'b0;
            has_rd       = 1'b0;
            has_func3    = 1'b0;
        end
    end

    // Load-use hazard against the load currently in the ID/EX register
    always_comb begin
        hazard = ID_VALID && ID_MEM_READ && (ID_RD != '0) && IF_VALID &&
                 ((uses_rs1 && (rs1 == ID_RD)) || (uses_rs2 && (rs2 == ID_RD)));
        ID_STALL  = hazard && !EX_FLUSH && !RST;
        load_live = IF_VALID && !EX_FLUSH && !hazard;
    end

    // Next ID/EX contents; anything not live becomes an all-zero bubble
    always_comb begin
        valid_d = 1'b0;
        pc_d    = '0;
        pc4_d   = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        imm_d   = '0;
        rs1_d   = '0;
        rs2_d   = '0;
        rd_d    = '0;
        f3_d    = '0;
        ctrl_d  = BUBBLE_CTRL;
        if (load_live) begin
            valid_d = 1'b1;
            pc_d    = IF_PC;
            pc4_d   = IF_PC + XLEN'(4);
            rd1_d   = uses_rs1 ? rdata1 : '0;
            rd2_d   = uses_rs2 ? rdata2 : '0;
            imm_d   = XLEN'($signed(imm_gen(IF_INSTRUCTION, imm_type)));
            rs1_d   = uses_rs1 ? rs1 : '0;
            rs2_d   = uses_rs2 ? rs2 : '0;
            rd_d    = has_rd ? rd : '0;
            f3_d    = has_func3 ? f3 : 3'b000;
            ctrl_d  = ctrl;
        end
    end

    // ID/EX output register
    always_ff @(posedge CLK) begin
        if (RST) begin
            ID_VALID        <= 1'b0;
            ID_PC           <= RESET_PC;
            ID_PC_PLUS4     <= RESET_PC + XLEN'(4);
            ID_READ_DATA1   <= '0;
            ID_READ_DATA2   <= '0;
            ID_IMMEDIATE    <= '0;
            ID_RS1          <= '0;
            ID_RS2          <= '0;
            ID_RD           <= '0;
            ID_FUNC3        <= '0;
            ID_ALU_CONTROL  <= '0;
            ID_WRITE_ENABLE <= 1'b0;
            ID_MEM_READ     <= 1'b0;
            ID_MEM_WRITE    <= 1'b0;
            ID_BRANCH       <= 1'b0;
            ID_JUMP         <= 1'b0;
            ID_IMM_SELECT   <= 1'b0;
            ID_ILLEGAL      <= 1'b0;
        end else begin
            ID_VALID        <= valid_d;
            ID_PC           <= pc_d;
            ID_PC_PLUS4     <= pc4_d;
            ID_READ_DATA1   <= rd1_d;
            ID_READ_DATA2   <= rd2_d;
            ID_IMMEDIATE    <= imm_d;
            ID_RS1          <= rs1_d;
            ID_RS2          <= rs2_d;
            ID_RD           <= rd_d;
            ID_FUNC3        <= f3_d;
            ID_ALU_CONTROL  <= ctrl_d.alu_control;
            ID_WRITE_ENABLE <= ctrl_d.write_enable;
            ID_MEM_READ     <= ctrl_d.mem_read;
            ID_MEM_WRITE    <= ctrl_d.mem_write;
            ID_BRANCH       <= ctrl_d.branch;
            ID_JUMP         <= ctrl_d.jump;
            ID_IMM_SELECT   <= ctrl_d.imm_select;
            ID_ILLEGAL      <= ctrl_d.illegal;
        end
    end

endmodule

// File: tb/tb_id_stage_hz.sv
// Self-checking bench for id_stage_hz: expected ID/EX contents are queued
// when an instruction is presented and compared after the next clock edge.
// A second XLEN=64 instance shares the stimulus for sign-extension checks.
module tb_id_stage_hz;
    import id_stage_hz_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, IF_VALID, WB_WRITE_ENABLE, EX_FLUSH;
    logic [31:0] IF_PC, IF_INSTRUCTION, WB_WRITE_DATA;
    logic [4:0]  WB_RD;

    logic        ID_STALL, ID_VALID, ID_WRITE_ENABLE, ID_MEM_READ, ID_MEM_WRITE;
    logic        ID_BRANCH, ID_JUMP, ID_IMM_SELECT, ID_ILLEGAL;
    logic [31:0] ID_PC, ID_PC_PLUS4, ID_READ_DATA1, ID_READ_DATA2, ID_IMMEDIATE;
    logic [4:0]  ID_RS1, ID_RS2, ID_RD, ID_ALU_CONTROL;
    logic [2:0]  ID_FUNC3;

    logic [63:0] if_pc_64, wb_data_64;
    logic        stall_64, valid_64, we_64, mr_64, mw_64, br_64, jmp_64, isel_64, ill_64;
    logic [63:0] pc_64, pc4_64, rd1_64, rd2_64, imm_64;
    logic [4:0]  rs1_64, rs2_64, rd_64, alu_64;
    logic [2:0]  f3_64;

    assign if_pc_64   = {32'b0, IF_PC};
    assign wb_data_64 = {32'b0, WB_WRITE_DATA};

    always #5 CLK = ~CLK;

    id_stage_hz #(.XLEN(32)) u_dut (
        .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IF_PC(IF_PC),
        .IF_INSTRUCTION(IF_INSTRUCTION), .WB_WRITE_ENABLE(WB_WRITE_ENABLE),
        .WB_RD(WB_RD), .WB_WRITE_DATA(WB_WRITE_DATA), .EX_FLUSH(EX_FLUSH),
        .ID_STALL(ID_STALL), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_PC_PLUS4(ID_PC_PLUS4), .ID_READ_DATA1(ID_READ_DATA1),
        .ID_READ_DATA2(ID_READ_DATA2), .ID_IMMEDIATE(ID_IMMEDIATE),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_FUNC3(ID_FUNC3),
        .ID_ALU_CONTROL(ID_ALU_CONTROL), .ID_WRITE_ENABLE(ID_WRITE_ENABLE),
        .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
        .ID_BRANCH(ID_BRANCH), .ID_JUMP(ID_JUMP), .ID_IMM_SELECT(ID_IMM_SELECT),
        .ID_ILLEGAL(ID_ILLEGAL)
    );

    id_stage_hz #(.XLEN(64)) u_dut64 (
        .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IF_PC(if_pc_64),
        .IF_INSTRUCTION(IF_INSTRUCTION), .WB_WRITE_ENABLE(WB_WRITE_ENABLE),
        .WB_RD(WB_RD), .WB_WRITE_DATA(wb_data_64), .EX_FLUSH(EX_FLUSH),
        .ID_STALL(stall_64), .ID_VALID(valid_64), .ID_PC(pc_64),
        .ID_PC_PLUS4(pc4_64), .ID_READ_DATA1(rd1_64), .ID_READ_DATA2(rd2_64),
        .ID_IMMEDIATE(imm_64), .ID_RS1(rs1_64), .ID_RS2(rs2_64), .ID_RD(rd_64),
        .ID_FUNC3(f3_64), .ID_ALU_CONTROL(alu_64), .ID_WRITE_ENABLE(we_64),
        .ID_MEM_READ(mr_64), .ID_MEM_WRITE(mw_64), .ID_BRANCH(br_64),
        .ID_JUMP(jmp_64), .ID_IMM_SELECT(isel_64), .ID_ILLEGAL(ill_64)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, pc4, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd, alu;
        logic [2:0]  f3;
        logic        we, mr, mw, br, jmp, isel, ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] I_ADD_3_1_2 = 32'h002081B3;
    localparam logic [31:0] I_ADD_4_0_0 = 32'h00000233;
    localparam logic [31:0] I_LW_5_1    = 32'h0000A283;
    localparam logic [31:0] I_ADD_6_5_5 = 32'h00528333;
    localparam logic [31:0] I_BEQ_M8    = 32'hFE208CE3;
    localparam logic [31:0] I_LUI_7     = 32'h123453B7;
    localparam logic [31:0] I_BAD_OPC   = 32'h0000007F;
    localparam logic [31:0] I_BAD_F7    = 32'h042080B3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk_bubble();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t mk_live(input logic [31:0] pc);
        exp_t e;
        e = '0;
        e.valid = 1'b1;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        return e;
    endfunction

    function automatic exp_t mk_reset();
        exp_t e;
        e = '0;
        e.pc4 = 32'd4;
        return e;
    endfunction

    function automatic exp_t mk_lw(input logic [31:0] pc, input logic [31:0] x1);
        exp_t e;
        e = mk_live(pc);
        e.rd1 = x1; e.rs1 = 5'd1; e.rd = 5'd5; e.f3 = 3'd2;
        e.we = 1'b1; e.mr = 1'b1; e.isel = 1'b1; e.alu = ALU_ADD;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        check("id_valid", 64'(ID_VALID),        64'(e.valid));
        check("id_pc",    64'(ID_PC),           64'(e.pc));
        check("id_pc4",   64'(ID_PC_PLUS4),     64'(e.pc4));
        check("id_rd1",   64'(ID_READ_DATA1),   64'(e.rd1));
        check("id_rd2",   64'(ID_READ_DATA2),   64'(e.rd2));
        check("id_imm",   64'(ID_IMMEDIATE),    64'(e.imm));
        check("id_rs1",   64'(ID_RS1),          64'(e.rs1));
        check("id_rs2",   64'(ID_RS2),          64'(e.rs2));
        check("id_rd",    64'(ID_RD),           64'(e.rd));
        check("id_func3", 64'(ID_FUNC3),        64'(e.f3));
        check("id_alu",   64'(ID_ALU_CONTROL),  64'(e.alu));
        check("id_we",    64'(ID_WRITE_ENABLE), 64'(e.we));
        check("id_mr",    64'(ID_MEM_READ),     64'(e.mr));
        check("id_mw",    64'(ID_MEM_WRITE),    64'(e.mw));
        check("id_br",    64'(ID_BRANCH),       64'(e.br));
        check("id_jmp",   64'(ID_JUMP),         64'(e.jmp));
        check("id_isel",  64'(ID_IMM_SELECT),   64'(e.isel));
        check("id_ill",   64'(ID_ILLEGAL),      64'(e.ill));
    endtask

    // Queue the expectation, let the edge happen, then score the output
    task automatic tick(input exp_t e);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        compare(sb.pop_front());
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        IF_VALID       = v;
        IF_PC          = pc;
        IF_INSTRUCTION = ins;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        WB_WRITE_ENABLE = we;
        WB_RD           = rd;
        WB_WRITE_DATA   = data;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        #1;
        check(tag, 64'(ID_STALL), 64'(exp));
    endtask

    initial begin
        exp_t e;
        RST = 1'b1;
        EX_FLUSH = 1'b0;
        fetch(1'b1, 32'h40, I_ADD_3_1_2);
        wb(1'b1, 5'd1, 32'hDEAD);

        // Reset overrides writeback and decode for two cycles
        check_stall("stall_in_reset", 1'b0);
        tick(mk_reset());
        tick(mk_reset());
        check("reset_pc64", pc4_64, 64'd4);
        RST = 1'b0;
        wb(1'b0, 5'd0, 32'h0);

        // Every register reads zero after reset
        for (int i = 1; i < 32; i++) begin
            logic [31:0] pc;
            logic [31:0] ins;
            pc  = 32'h100 + 32'(4 * i);
            ins = {7'b0, 5'(i), 5'(i), 3'b000, 5'd1, 7'b0110011};
            fetch(1'b1, pc, ins);
            e = mk_live(pc);
            e.rs1 = 5'(i); e.rs2 = 5'(i); e.rd = 5'd1;
            e.we = 1'b1; e.alu = ALU_ADD;
            tick(e);
        end

        // Writeback with no instruction: bubble, but the write lands
        fetch(1'b0, 32'h1FC, I_ADD_3_1_2);
        wb(1'b1, 5'd2, 32'd5);
        tick(mk_bubble());

        // Same-cycle write-through bypass
        fetch(1'b1, 32'h200, I_ADD_3_1_2);
        wb(1'b1, 5'd1, 32'hA);
        e = mk_live(32'h200);
        e.rd1 = 32'hA; e.rd2 = 32'd5; e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd3;
        e.we = 1'b1; e.alu = ALU_ADD;
        tick(e);

        // x0 ignores writes, including the bypass path
        fetch(1'b1, 32'h208, I_ADD_4_0_0);
        wb(1'b1, 5'd0, 32'hFF);
        e = mk_live(32'h208);
        e.rd = 5'd4; e.we = 1'b1; e.alu = ALU_ADD;
        tick(e);
        wb(1'b0, 5'd0, 32'h0);
        tick(e);

        // Load-use: one stall cycle, one bubble, then the consumer
        fetch(1'b1, 32'h300, I_LW_5_1);
        check_stall("stall_before_load", 1'b0);
        tick(mk_lw(32'h300, 32'hA));
        fetch(1'b1, 32'h304, I_ADD_6_5_5);
        check_stall("stall_load_use", 1'b1);
        tick(mk_bubble());
        check_stall("stall_released", 1'b0);
        e = mk_live(32'h304);
        e.rs1 = 5'd5; e.rs2 = 5'd5; e.rd = 5'd6; e.we = 1'b1; e.alu = ALU_ADD;
        tick(e);

        // Flush beats stall, and kills a valid fetch on its own
        fetch(1'b1, 32'h310, I_LW_5_1);
        tick(mk_lw(32'h310, 32'hA));
        fetch(1'b1, 32'h314, I_ADD_6_5_5);
        EX_FLUSH = 1'b1;
        check_stall("stall_under_flush", 1'b0);
        tick(mk_bubble());
        fetch(1'b1, 32'h318, I_LUI_7);
        tick(mk_bubble());
        EX_FLUSH = 1'b0;

        // Branch immediate, both widths
        fetch(1'b1, 32'h400, I_BEQ_M8);
        e = mk_live(32'h400);
        e.rd1 = 32'hA; e.rd2 = 32'd5; e.rs1 = 5'd1; e.rs2 = 5'd2;
        e.br = 1'b1; e.alu = ALU_SUB; e.imm = 32'hFFFF_FFF8;
        tick(e);
        check("imm64_beq", imm_64, 64'hFFFF_FFFF_FFFF_FFF8);
        check("pc4_64_beq", pc4_64, 64'h404);

        // Upper immediate
        fetch(1'b1, 32'h404, I_LUI_7);
        e = mk_live(32'h404);
        e.rd = 5'd7; e.we = 1'b1; e.isel = 1'b1; e.alu = ALU_PASS_B;
        e.imm = 32'h1234_5000;
        tick(e);
        check("imm64_lui", imm_64, 64'h0000_0000_1234_5000);

        // Illegal opcode and illegal funct7
        fetch(1'b1, 32'h408, I_BAD_OPC);
        e = mk_live(32'h408);
        e.ill = 1'b1;
        tick(e);
        fetch(1'b1, 32'h40C, I_BAD_F7);
        e = mk_live(32'h40C);
        e.ill = 1'b1;
        tick(e);

        // Reset during a stall discards the stalled instruction
        fetch(1'b1, 32'h500, I_LW_5_1);
        tick(mk_lw(32'h500, 32'hA));
        fetch(1'b1, 32'h504, I_ADD_6_5_5);
        RST = 1'b1;
        check_stall("stall_reset_mid", 1'b0);
        tick(mk_reset());
        RST = 1'b0;
        fetch(1'b0, 32'h504, I_ADD_6_5_5);
        tick(mk_bubble());

        // Register file was cleared by that reset
        fetch(1'b1, 32'h600, I_ADD_3_1_2);
        e = mk_live(32'h600);
        e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd3; e.we = 1'b1; e.alu = ALU_ADD;
        tick(e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
